// File: rtl/softmax_r2b_sched.sv
// Drains row-wise softmax units into the R2B converter in ascending row order, tile by tile.
// Optional watchdog on stalled rows/handshakes is built when SOFTMAX_SCHED_WDOG_EN is defined.
//
// state    | meaning
// IDLE     | scheduler parked, waiting for en
// WAIT_ROW | waiting for row_done of the current row
// STREAM   | presenting tiles of the current row to R2B
// CLEAR    | one-cycle release pulse to the drained row
module softmax_r2b_sched #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_TILES      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         en,
  input  logic [NUM_ROWS-1:0]                          row_done,
  input  logic                                         r2b_ready,
  output logic                                         r2b_valid,
  output logic                                         r2b_last,
  output logic [$clog2(NUM_ROWS)-1:0]                  row_sel,
  output logic [((NUM_TILES > 1) ? $clog2(NUM_TILES) : 1)-1:0] tile_sel,
  output logic [NUM_ROWS-1:0]                          row_clear,
  output logic                                         busy,
  output logic [15:0]                                  slice_cnt,
  output logic                                         wdog_err
);

  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ROW = 2'd1;
  localparam logic [1:0] STREAM   = 2'd2;
  localparam logic [1:0] CLEAR    = 2'd3;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);

  logic [1:0]          state, state_nxt;
  logic [ROW_W-1:0]    row_nxt;
  logic [TILE_W-1:0]   tile_nxt;
  logic                valid_nxt;
  logic                last_nxt;
  logic [NUM_ROWS-1:0] clear_nxt;
  logic [15:0]         slice_nxt;
  logic                xfer;

  assign xfer = r2b_valid & r2b_ready;

  always_comb begin
    state_nxt = state;
    row_nxt   = row_sel;
    tile_nxt  = tile_sel;
    valid_nxt = 1'b0;
    clear_nxt = '0;
    slice_nxt = slice_cnt;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = WAIT_ROW;
          row_nxt   = '0;
          tile_nxt  = '0;
        end
      end
      WAIT_ROW: begin
        if (row_done[row_sel]) begin
          state_nxt = STREAM;
          valid_nxt = 1'b1;
        end
      end
      STREAM: begin
        valid_nxt = 1'b1;
        if (xfer) begin
          if (tile_sel == TILE_LAST) begin
            state_nxt = CLEAR;
            valid_nxt = 1'b0;
            tile_nxt  = '0;
            clear_nxt = NUM_ROWS'(1) << row_sel;
          end else begin
            tile_nxt = tile_sel + TILE_W'(1);
          end
        end
      end
      CLEAR: begin
        if (row_sel == ROW_LAST) begin
          row_nxt   = '0;
          slice_nxt = slice_cnt + 16'd1;
          state_nxt = en ? WAIT_ROW : IDLE;
        end else begin
          row_nxt   = row_sel + ROW_W'(1);
          state_nxt = WAIT_ROW;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // r2b_last is derived from next-state values so it stays a pure register output
  assign last_nxt = valid_nxt & (row_nxt == ROW_LAST) & (tile_nxt == TILE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r2b_valid <= 1'b0;
      r2b_last  <= 1'b0;
      row_sel   <= '0;
      tile_sel  <= '0;
      row_clear <= '0;
      busy      <= 1'b0;
      slice_cnt <= '0;
    end else begin
      state     <= state_nxt;
      r2b_valid <= valid_nxt;
      r2b_last  <= last_nxt;
      row_sel   <= row_nxt;
      tile_sel  <= tile_nxt;
      row_clear <= clear_nxt;
      busy      <= (state_nxt != IDLE);
      slice_cnt <= slice_nxt;
    end
  end

`ifdef SOFTMAX_SCHED_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;

  assign wd_run = (state == WAIT_ROW) | ((state == STREAM) & ~r2b_ready);

  // Watchdog only flags; the FSM keeps waiting so no data is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
    end else if ((state_nxt != state) || xfer) begin
      wd_cnt <= '0;
    end else if (wd_run && (wd_cnt != WD_W'(TIMEOUT_CYCLES))) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_r2b_sched.sv
// Scoreboard bench for softmax_r2b_sched: expected transfers and clear pulses are queued
// when a slice is launched and popped by a negedge monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_softmax_r2b_sched;

  localparam int NR = 4;
  localparam int NT = 2;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [NR-1:0] row_done;
  logic          r2b_ready;
  logic          r2b_valid;
  logic          r2b_last;
  logic [1:0]    row_sel;
  logic [0:0]    tile_sel;
  logic [NR-1:0] row_clear;
  logic          busy;
  logic [15:0]   slice_cnt;
  logic          wdog_err;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  int exp_slices = 0;
  int exp_q[$];
  int clr_q[$];

  softmax_r2b_sched #(.NUM_ROWS(NR), .NUM_TILES(NT), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .row_done(row_done), .r2b_ready(r2b_ready),
    .r2b_valid(r2b_valid), .r2b_last(r2b_last), .row_sel(row_sel), .tile_sel(tile_sel),
    .row_clear(row_clear), .busy(busy), .slice_cnt(slice_cnt), .wdog_err(wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encoding of one transfer: row*16 + tile*2 + last
  task automatic push_slice();
    for (int r = 0; r < NR; r++) begin
      for (int t = 0; t < NT; t++) exp_q.push_back(r * 16 + t * 2 + ((r == NR-1 && t == NT-1) ? 1 : 0));
      clr_q.push_back(1 << r);
    end
  endtask

  task automatic wait_row(input int r);
    int n;
    n = 0;
    while (int'(row_sel) != r && n < 100) begin
      tick();
      n++;
    end
    chk("wait_row", int'(row_sel), r);
  endtask

  task automatic wait_slice();
    int n;
    n = 0;
    while (int'(slice_cnt) != exp_slices && n < 200) begin
      tick();
      n++;
    end
    chk("slice_cnt", int'(slice_cnt), exp_slices);
  endtask

  task automatic launch();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (r2b_valid && r2b_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) chk("unexpected_xfer", int'(row_sel) * 16 + int'(tile_sel) * 2 + int'(r2b_last), -1);
        else chk("xfer", int'(row_sel) * 16 + int'(tile_sel) * 2 + int'(r2b_last), exp_q.pop_front());
      end
      if (row_clear != '0) begin
        if (clr_q.size() == 0) chk("unexpected_clear", int'(row_clear), 0);
        else chk("row_clear", int'(row_clear), clr_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    int seen;
    rst_n = 1'b0; en = 1'b0; row_done = '0; r2b_ready = 1'b0;
    #1;
    chk("rst_valid", int'(r2b_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_slice", int'(slice_cnt), 0);
    chk("rst_row_clear", int'(row_clear), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // basic slice, en pulsed once
    push_slice();
    base = xfer_cnt;
    row_done = 4'hf; r2b_ready = 1'b1;
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("lat_valid_e0", int'(r2b_valid), 0);
    chk("lat_busy_e0", int'(busy), 1);
    tick();
    chk("lat_valid_e1", int'(r2b_valid), 1);
    chk("lat_row_tile", int'(row_sel) * 2 + int'(tile_sel), 0);
    exp_slices++;
    wait_slice();
    tick(); tick();
    chk("basic_xfers", xfer_cnt - base, 8);
    chk("basic_idle", int'(busy), 0);

    // backpressure at (1,0)
    push_slice();
    base = xfer_cnt;
    row_done = 4'b0001; r2b_ready = 1'b1;
    launch();
    wait_row(1);
    r2b_ready = 1'b0; row_done = 4'hf;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(r2b_valid), 1);
      chk("bp_pos", int'(row_sel) * 2 + int'(tile_sel), 2);
      tick();
    end
    r2b_ready = 1'b1;
    exp_slices++;
    wait_slice();
    chk("bp_xfers", xfer_cnt - base, 8);

    // out-of-order done
    push_slice();
    row_done = 4'b1000;
    launch();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (r2b_valid) seen++;
      tick();
    end
    chk("ooo_no_valid", seen, 0);
    row_done = 4'b1001;
    wait_row(1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (r2b_valid || row_sel != 2'd1) seen++;
      tick();
    end
    chk("ooo_hold_row1", seen, 0);
    row_done = 4'hf;
    exp_slices++;
    wait_slice();

    // en held then dropped during row 2
    push_slice();
    en = 1'b1;
    tick();
    wait_row(2);
    en = 1'b0;
    exp_slices++;
    wait_slice();
    tick(); tick();
    chk("endrop_busy", int'(busy), 0);

    // async reset while stalled at (2,1)
    push_slice();
    row_done = 4'b0011; r2b_ready = 1'b1;
    launch();
    wait_row(2);
    r2b_ready = 1'b0; row_done = 4'hf;
    tick();
    r2b_ready = 1'b1;
    tick();
    r2b_ready = 1'b0;
    chk("rst_pos_21", int'(row_sel) * 2 + int'(tile_sel), 5);
    chk("rst_pre_valid", int'(r2b_valid), 1);
    exp_q.delete();
    clr_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(r2b_valid), 0);
    chk("arst_last", int'(r2b_last), 0);
    chk("arst_row", int'(row_sel), 0);
    chk("arst_tile", int'(tile_sel), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_slice", int'(slice_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    exp_slices = 0;
    tick();
    push_slice();
    base = xfer_cnt;
    r2b_ready = 1'b1;
    launch();
    exp_slices++;
    wait_slice();
    chk("post_rst_xfers", xfer_cnt - base, 8);

`ifdef SOFTMAX_SCHED_WDOG_EN
    row_done = '0;
    launch();
    repeat (15) tick();
    chk("wdog_early", int'(wdog_err), 0);
    tick();
    chk("wdog_set", int'(wdog_err), 1);
    push_slice();
    row_done = 4'hf;
    exp_slices++;
    wait_slice();
    chk("wdog_sticky", int'(wdog_err), 1);
`else
    chk("wdog_off", int'(wdog_err), 0);
`endif

    tick(); tick();
    chk("sb_xfer_empty", exp_q.size(), 0);
    chk("sb_clr_empty", clr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/softmax_r2b_sched.md
Name: softmax_r2b_sched

Overview:
Schedules the drain of a bank of row-wise softmax units into the R2B converter. Rows are consumed strictly in ascending order (0..NUM_ROWS-1). Each row is streamed as NUM_TILES tiles under a valid/ready handshake, and the row's softmax unit is released with a one-cycle clear pulse once its last tile is accepted. The block marks the last tile of each slice and returns to row 0 for the next slice. It owns the sequencing only; the tile data path is steered by the row_sel and tile_sel outputs.

Parameters:
NUM_ROWS, 4, number of softmax row units (NUM_CORES x BLOCK_SIZE); must be >= 2
NUM_TILES, 2, softmax output tiles per row fed to R2B; must be >= 1
TIMEOUT_CYCLES, 1024, watchdog limit (used only with SOFTMAX_SCHED_WDOG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scheduler enable; sampled every cycle
row_done  in  NUM_ROWS  level per row: result held and valid until cleared
r2b_ready  in  1  R2B accepts a tile this cycle
r2b_valid  out  1  tile on the selected row/tile is valid
r2b_last  out  1  high with r2b_valid on the final tile of the final row
row_sel  out  $clog2(NUM_ROWS)  row currently being drained
tile_sel  out  $clog2(NUM_TILES) (min 1)  tile index within the row
row_clear  out  NUM_ROWS  one-hot, one-cycle release pulse to the softmax row
busy  out  1  high in any state other than IDLE
slice_cnt  out  16  completed slices; wraps at 2^16
wdog_err  out  1  sticky watchdog flag; constant 0 when the feature is absent

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0: r2b_valid, r2b_last, row_sel, tile_sel, row_clear, busy, slice_cnt, wdog_err.
- All outputs are registered.
- FSM states:
  - IDLE: if en, go to WAIT_ROW with row_sel=0 and tile_sel=0.
  - WAIT_ROW: r2b_valid=0. If row_done[row_sel], go to STREAM and assert r2b_valid next cycle. Latency from row_done to r2b_valid is 1 cycle.
  - STREAM: r2b_valid=1. A transfer occurs on r2b_valid & r2b_ready. r2b_valid, tile_sel and row_sel are held stable while r2b_ready=0.
    - Transfer with tile_sel<NUM_TILES-1: tile_sel+1, stay in STREAM (back-to-back tiles, no bubble).
    - Transfer with tile_sel==NUM_TILES-1: go to CLEAR.
  - CLEAR: one cycle. row_clear[row_sel]=1, r2b_valid=0, tile_sel set to 0.
    - row_sel<NUM_ROWS-1: row_sel+1, go to WAIT_ROW.
    - row_sel==NUM_ROWS-1: row_sel=0, slice_cnt+1. Go to WAIT_ROW if en, otherwise IDLE.
- r2b_last is combinationally equivalent to r2b_valid & (row_sel==NUM_ROWS-1) & (tile_sel==NUM_TILES-1), but is produced from registered state.
- Out-of-order done: a row_done on a row other than row_sel is ignored until that row becomes current. No skip and no reorder.
- en deasserted mid-slice: the current slice completes. en is checked only in IDLE and at the slice boundary.
- row_done dropping during STREAM (protocol violation): the stream continues regardless. The done signal is not re-sampled until the next WAIT_ROW.
- Row-to-row overhead is 2 cycles (CLEAR + WAIT_ROW) when the next row_done is already high.
- Async reset mid-stream: everything returns to IDLE immediately, and no row_clear pulse is emitted.

Optional Feature:
Macro SOFTMAX_SCHED_WDOG_EN.
- Defined: a watchdog counter runs in WAIT_ROW and in STREAM with r2b_ready=0. It resets on every state change and on every transfer. On reaching TIMEOUT_CYCLES, wdog_err is set sticky (cleared only by rst_n). The FSM keeps waiting and does not abort.
- Undefined: the counter is not built, and wdog_err is tied to 0.

Test Plan:
- Basic slice (NUM_ROWS=4, NUM_TILES=2, ready=1, all row_done high, en=1):
  - 8 transfers in order (0,0)(0,1)(1,0)(1,1)...(3,1).
  - r2b_last only on (3,1).
  - row_clear pulses 0x1,0x2,0x4,0x8.
  - slice_cnt=1.
  - The first r2b_valid appears 2 cycles after en (IDLE->WAIT_ROW->STREAM).
- Backpressure: r2b_ready low for 5 cycles at (1,0) -> r2b_valid, row_sel=1 and tile_sel=0 held stable all 5 cycles; no duplicate or lost transfer; total transfers still 8.
- Out-of-order done: row_done=4'b1000 first, then 4'b1001 10 cycles later -> no r2b_valid until row 0 is done; row 3 is not drained before rows 1 and 2.
- en dropped during row 2 -> slice finishes with r2b_last, slice_cnt increments, FSM goes to IDLE, busy=0.
- Async reset asserted mid-STREAM at (2,1) -> all outputs are 0 without waiting for a clock edge; after release, a new slice restarts at row 0.
- With SOFTMAX_SCHED_WDOG_EN and TIMEOUT_CYCLES=16, row_done held low -> wdog_err=1 after 16 WAIT_ROW cycles and remains set after row_done arrives; the slice then completes normally.
